// File: rtl/mac_acc_block_0.sv
// Accumulator stage after the block-0 multiplier: sums product beats into a cfg-selected width
// and presents the result on a registered valid/ready port. Optional clamping via MAC_ACC_SAT_EN.
module mac_acc_block_0 #(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [MAC_INT_WIDTH-1:0]  C,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_INT_WIDTH-1:0]  out_data,
  output logic                      out_ovf
);

  localparam int W_SINGLE = (5 * MAC_MIN_WIDTH) / 2;
  localparam int W_DUAL   = (7 * MAC_MIN_WIDTH) / 2;

`ifdef MAC_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  typedef enum logic [1:0] {MODE_SINGLE, MODE_DUAL, MODE_QUAD} mode_t;

  state_t                      state, state_n;
  logic [MAC_INT_WIDTH-1:0]    acc, acc_n;
  logic                        ovf, ovf_n;
  logic [MAC_CONF_WIDTH-1:0]   cfg_q, cfg_n;

  logic                        accept;
  logic                        first_beat;
  logic [MAC_CONF_WIDTH-1:0]   cfg_eff;
  mode_t                       mode;
  logic [MAC_INT_WIDTH-1:0]    mask;
  logic [MAC_INT_WIDTH-1:0]    c_masked;
  logic [MAC_INT_WIDTH-1:0]    sum;
  logic [MAC_INT_WIDTH-1:0]    sum_w;
  logic [MAC_INT_WIDTH-1:0]    clamp;
  logic                        ovf_now;

  assign in_ready   = en & ((state != HOLD) | out_ready);
  assign accept     = in_valid & in_ready;
  assign first_beat = accept & (state != ACCUM);
  assign cfg_eff    = first_beat ? cfg : cfg_q;

  // Encoding 11 falls back to single mode.
  always_comb begin
    case (cfg_eff[1:0])
      2'b01:   mode = MODE_DUAL;
      2'b10:   mode = MODE_QUAD;
      default: mode = MODE_SINGLE;
    endcase
  end

  always_comb begin
    case (mode)
      MODE_DUAL: mask = {{(MAC_INT_WIDTH - W_DUAL){1'b0}}, {W_DUAL{1'b1}}};
      MODE_QUAD: mask = {MAC_INT_WIDTH{1'b1}};
      default:   mask = {{(MAC_INT_WIDTH - W_SINGLE){1'b0}}, {W_SINGLE{1'b1}}};
    endcase
  end

  assign c_masked = C & mask;
  assign sum      = acc + c_masked;
  assign sum_w    = sum & mask;

  // Unsigned widths are narrower than the adder, so their carry lands inside sum.
  always_comb begin
    case (mode)
      MODE_DUAL: ovf_now = sum[W_DUAL];
      MODE_QUAD: ovf_now = (acc[MAC_INT_WIDTH-1] == c_masked[MAC_INT_WIDTH-1]) &&
                           (sum[MAC_INT_WIDTH-1] != acc[MAC_INT_WIDTH-1]);
      default:   ovf_now = sum[W_SINGLE];
    endcase
  end

  always_comb begin
    if (mode == MODE_QUAD) begin
      clamp = acc[MAC_INT_WIDTH-1] ? {1'b1, {(MAC_INT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(MAC_INT_WIDTH-1){1'b1}}};
    end else begin
      clamp = mask;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    ovf_n   = ovf;
    cfg_n   = cfg_q;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_n   = c_masked;
          ovf_n   = 1'b0;
          cfg_n   = cfg;
          state_n = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (SAT_EN && ovf) begin
            acc_n = acc;
          end else if (ovf_now) begin
            ovf_n = 1'b1;
            acc_n = SAT_EN ? clamp : sum_w;
          end else begin
            acc_n = sum_w;
          end
          state_n = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (en && out_ready) begin
          state_n = IDLE;
          // A beat arriving with the handshake starts the next dot product immediately.
          if (accept) begin
            acc_n   = c_masked;
            ovf_n   = 1'b0;
            cfg_n   = cfg;
            state_n = in_last ? HOLD : ACCUM;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cfg_q <= '0;
    end else if (en) begin
      state <= state_n;
      acc   <= acc_n;
      ovf   <= ovf_n;
      cfg_q <= cfg_n;
    end
  end

  assign out_valid = (state == HOLD);
  assign out_data  = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_mac_acc_block_0.sv
// Directed bench for mac_acc_block_0: hand-computed sums across widths, overflow,
// backpressure, reset and clock-enable behaviour. Expectations follow MAC_ACC_SAT_EN.
module tb_mac_acc_block_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  cfg;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [39:0] C;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

`ifdef MAC_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  mac_acc_block_0 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg       (cfg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] c, input bit last, input logic [1:0] cf);
    int waited;
    in_valid = 1'b1;
    C        = c;
    in_last  = last;
    cfg      = cf;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", {39'd0, in_ready}, 40'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cfg = 2'b00; in_valid = 1'b0; in_last = 1'b0;
    C = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {39'd0, out_valid}, 40'd0);
    check("rst_out_data", out_data, 40'd0);
    check("rst_out_ovf", {39'd0, out_ovf}, 40'd0);
    check("rst_in_ready", {39'd0, in_ready}, 40'd1);

    // single: 0x10 + 0x20 + 0x30
    out_ready = 1'b1;
    send(40'h10, 0, 2'b00);
    check("t1_not_valid_mid", {39'd0, out_valid}, 40'd0);
    send(40'h20, 0, 2'b00);
    send(40'h30, 1, 2'b00);
    check("t1_valid", {39'd0, out_valid}, 40'd1);
    check("t1_data", out_data, 40'h60);
    check("t1_ovf", {39'd0, out_ovf}, 40'd0);
    tick();
    check("t1_drained", {39'd0, out_valid}, 40'd0);

    // single: 17 x 0xFFFF = 0x10FFEF
    for (int i = 0; i < 16; i++) send(40'hFFFF, 0, 2'b00);
    send(40'hFFFF, 1, 2'b00);
    check("t2_valid", {39'd0, out_valid}, 40'd1);
    check("t2_data", out_data, SAT ? 40'hF_FFFF : 40'h0_FFEF);
    check("t2_ovf", {39'd0, out_ovf}, 40'd1);
    tick();

    // quad signed: -1 + 5, cfg change on second beat ignored
    send(40'hFF_FFFF_FFFF, 0, 2'b10);
    send(40'h00_0000_0005, 1, 2'b00);
    check("t3_data", out_data, 40'h4);
    check("t3_ovf", {39'd0, out_ovf}, 40'd0);
    tick();

    // quad positive overflow
    send(40'h7F_FFFF_FFFF, 0, 2'b10);
    send(40'h1, 1, 2'b10);
    check("t3b_data", out_data, SAT ? 40'h7F_FFFF_FFFF : 40'h80_0000_0000);
    check("t3b_ovf", {39'd0, out_ovf}, 40'd1);
    tick();

    // dual: upper bits masked, carry out of bit 27
    send(40'hAB_0FFF_FFFF, 0, 2'b01);
    send(40'h1, 1, 2'b01);
    check("t3c_data", out_data, SAT ? 40'h0FFF_FFFF : 40'h0);
    check("t3c_ovf", {39'd0, out_ovf}, 40'd1);
    tick();

    // cfg 11 acts as single: 0xFFFFF + 0x3 wraps at 20 bits
    send(40'hF_FFFF, 0, 2'b11);
    send(40'h3, 1, 2'b11);
    check("t3d_data", out_data, SAT ? 40'hF_FFFF : 40'h2);
    check("t3d_ovf", {39'd0, out_ovf}, 40'd1);
    tick();

    // backpressure then back-to-back single beat
    out_ready = 1'b0;
    send(40'h5, 1, 2'b00);
    check("t4_valid", {39'd0, out_valid}, 40'd1);
    check("t4_in_ready", {39'd0, in_ready}, 40'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_hold_valid", {39'd0, out_valid}, 40'd1);
      check("t4_hold_data", out_data, 40'h5);
      check("t4_hold_ready", {39'd0, in_ready}, 40'd0);
    end
    in_valid = 1'b1; C = 40'h7; in_last = 1'b1; cfg = 2'b00; out_ready = 1'b1;
    #1;
    check("t4_ready_on_handshake", {39'd0, in_ready}, 40'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check("t4_b2b_valid", {39'd0, out_valid}, 40'd1);
    check("t4_b2b_data", out_data, 40'h7);
    tick();
    check("t4_drained", {39'd0, out_valid}, 40'd0);

    // reset mid-accumulation discards partial sum
    send(40'h1, 0, 2'b00);
    send(40'h1, 0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_valid", {39'd0, out_valid}, 40'd0);
    check("t5_rst_data", out_data, 40'h0);
    send(40'h3, 1, 2'b00);
    check("t5_data", out_data, 40'h3);
    tick();

    // en low mid-accumulation freezes and blocks a presented beat
    send(40'h1, 0, 2'b00);
    en = 1'b0;
    in_valid = 1'b1; C = 40'h100; in_last = 1'b1;
    #1;
    check("t6_en_in_ready", {39'd0, in_ready}, 40'd0);
    tick(); tick();
    check("t6_en_valid", {39'd0, out_valid}, 40'd0);
    check("t6_en_data", out_data, 40'h1);
    in_valid = 1'b0; in_last = 1'b0;
    en = 1'b1;
    send(40'h2, 1, 2'b00);
    check("t6_data", out_data, 40'h3);

    // en low during HOLD keeps the result presented
    en = 1'b0;
    tick(); tick();
    check("t6_hold_valid", {39'd0, out_valid}, 40'd1);
    check("t6_hold_data", out_data, 40'h3);
    en = 1'b1;
    tick();
    check("t6_drained", {39'd0, out_valid}, 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
